// File: rtl/l1_core_responder.sv
// L1 line-array responder: a scalar port and two vector ports share a DEPTH-line
// array through a round-robin arbiter; every accepted request answers two cycles later.
module l1_core_responder #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 64,
  parameter int VEC_DATA_WIDTH = 512,
  parameter int DEPTH          = 256
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      REQ_VALID,
  input  logic                      RW_REQ,
  input  logic [ADDR_WIDTH-1:0]     D_ADDR,
  input  logic [DATA_WIDTH-1:0]     D_OUT,
  output logic                      REQ_READY,
  output logic [DATA_WIDTH-1:0]     D_IN,
  output logic                      D_VALID,
  input  logic                      VEC_REQ_VALID [0:1],
  input  logic                      VEC_RW_REQ,
  input  logic [ADDR_WIDTH-1:0]     VEC_DADDR [0:1],
  input  logic [VEC_DATA_WIDTH-1:0] VEC_DOUT,
  output logic                      VEC_REQ_READY [0:1],
  output logic [VEC_DATA_WIDTH-1:0] VEC_DIN [0:1],
  output logic                      VEC_DVALID [0:1],
  output logic                      INIT_DONE
);

  // Handshake: a request is accepted in the cycle where its VALID and READY are
  // both high; READY is combinational and only the arbitration winner sees it.
  // Responses carry no backpressure and appear two cycles after acceptance.

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LSB   = 6;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] init_cnt_q, init_cnt_d;

  logic [VEC_DATA_WIDTH-1:0] mem [DEPTH];

  // Arbiter: requester 0 = scalar, 1 = vec0, 2 = vec1
  logic [3:0] req;
  logic [2:0] gnt;
  logic       gnt_any;
  logic [1:0] gnt_idx;
  logic [1:0] ptr_q, ptr_d;
  logic [5:0] order;

  logic [IDX_W-1:0] acc_idx;
  logic [2:0]       acc_word;
  logic             acc_write;

  logic             s1_valid;
  logic [1:0]       s1_port;
  logic             s1_write;
  logic [IDX_W-1:0] s1_idx;
  logic [2:0]       s1_word;

  logic [VEC_DATA_WIDTH-1:0] rd_line;
  logic [DATA_WIDTH-1:0]     rd_word;

  // INIT_DONE is a direct decode of the FSM state and doubles as its observation point
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    INIT_DONE  = 1'b0;
    unique case (state_q)
      S_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == IDX_W'(DEPTH - 1)) state_d = S_RUN;
      end
      default: INIT_DONE = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    req     = {1'b0, VEC_REQ_VALID[1], VEC_REQ_VALID[0], REQ_VALID};
    gnt     = 3'b000;
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    ptr_d   = ptr_q;
    // order holds the search sequence, highest priority in the low two bits
    unique case (ptr_q)
      2'd1:    order = {2'd0, 2'd2, 2'd1};
      2'd2:    order = {2'd1, 2'd0, 2'd2};
      default: order = {2'd2, 2'd1, 2'd0};
    endcase
    if (state_q == S_RUN) begin
      for (int k = 2; k >= 0; k--) begin
        if (req[order[k*2 +: 2]]) begin
          gnt_any = 1'b1;
          gnt_idx = order[k*2 +: 2];
        end
      end
    end
    if (gnt_any) begin
      unique case (gnt_idx)
        2'd1: begin
          gnt   = 3'b010;
          ptr_d = 2'd2;
        end
        2'd2: begin
          gnt   = 3'b100;
          ptr_d = 2'd0;
        end
        default: begin
          gnt   = 3'b001;
          ptr_d = 2'd1;
        end
      endcase
    end
  end

  assign REQ_READY        = gnt[0];
  assign VEC_REQ_READY[0] = gnt[1];
  assign VEC_REQ_READY[1] = gnt[2];

  always_comb begin
    acc_idx   = D_ADDR[LSB +: IDX_W];
    acc_write = gnt[0] & RW_REQ;
    if (gnt[1]) begin
      acc_idx   = VEC_DADDR[0][LSB +: IDX_W];
      acc_write = VEC_RW_REQ;
    end else if (gnt[2]) begin
      acc_idx   = VEC_DADDR[1][LSB +: IDX_W];
      acc_write = 1'b0;
    end
  end

  assign acc_word = D_ADDR[5:3];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ptr_q    <= 2'd0;
      s1_valid <= 1'b0;
      s1_port  <= 2'd0;
      s1_write <= 1'b0;
      s1_idx   <= '0;
      s1_word  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      s1_valid <= gnt_any;
      s1_port  <= gnt_idx;
      s1_write <= acc_write;
      s1_idx   <= acc_idx;
      s1_word  <= acc_word;
    end
  end

  // Writes land at the end of the acceptance cycle, so a read accepted one cycle
  // later reads the array after the update and never sees stale data.
  always_ff @(posedge CLK) begin
    if (state_q == S_INIT) begin
      mem[init_cnt_q] <= '0;
    end else if (gnt[0] && RW_REQ) begin
      mem[acc_idx][acc_word*DATA_WIDTH +: DATA_WIDTH] <= D_OUT;
    end else if (gnt[1] && VEC_RW_REQ) begin
      mem[acc_idx] <= VEC_DOUT;
    end
  end

  assign rd_line = mem[s1_idx];
  assign rd_word = rd_line[s1_word*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      D_VALID       <= 1'b0;
      D_IN          <= '0;
      VEC_DVALID[0] <= 1'b0;
      VEC_DVALID[1] <= 1'b0;
      VEC_DIN[0]    <= '0;
      VEC_DIN[1]    <= '0;
    end else begin
      D_VALID       <= s1_valid && (s1_port == 2'd0);
      VEC_DVALID[0] <= s1_valid && (s1_port == 2'd1);
      VEC_DVALID[1] <= s1_valid && (s1_port == 2'd2);
      if (s1_valid) begin
        unique case (s1_port)
          2'd1:    VEC_DIN[0] <= s1_write ? '0 : rd_line;
          2'd2:    VEC_DIN[1] <= rd_line;
          default: D_IN       <= s1_write ? '0 : rd_word;
        endcase
      end
    end
  end

  // Byte offsets and address bits above the array span are ignored by design
  logic unused_addr_bits;
  assign unused_addr_bits = ^{D_ADDR[2:0], D_ADDR[ADDR_WIDTH-1:LSB+IDX_W],
                              VEC_DADDR[0][LSB-1:0], VEC_DADDR[0][ADDR_WIDTH-1:LSB+IDX_W],
                              VEC_DADDR[1][LSB-1:0], VEC_DADDR[1][ADDR_WIDTH-1:LSB+IDX_W]};

endmodule

// File: tb/tb_l1_core_responder.sv
// Self-checking bench for l1_core_responder: directed scenarios plus random traffic
// checked against a line-array reference model with per-port expected queues.
module tb_l1_core_responder;
  localparam int DW    = 64;
  localparam int AW    = 64;
  localparam int VW    = 512;
  localparam int DEPTH = 256;

  // clock / reset
  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  int   cyc   = 0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  logic          REQ_VALID = 1'b0;
  logic          RW_REQ    = 1'b0;
  logic [AW-1:0] D_ADDR    = '0;
  logic [DW-1:0] D_OUT     = '0;
  logic          REQ_READY;
  logic [DW-1:0] D_IN;
  logic          D_VALID;
  logic          vv0 = 1'b0, vv1 = 1'b0;
  logic [AW-1:0] va0 = '0, va1 = '0;
  logic          VEC_RW_REQ = 1'b0;
  logic [VW-1:0] VEC_DOUT   = '0;
  logic          vec_req_valid [0:1];
  logic [AW-1:0] vec_daddr [0:1];
  logic          VEC_REQ_READY [0:1];
  logic [VW-1:0] VEC_DIN [0:1];
  logic          VEC_DVALID [0:1];
  logic          INIT_DONE;

  assign vec_req_valid[0] = vv0;
  assign vec_req_valid[1] = vv1;
  assign vec_daddr[0]     = va0;
  assign vec_daddr[1]     = va1;

  l1_core_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VEC_DATA_WIDTH(VW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .RW_REQ(RW_REQ), .D_ADDR(D_ADDR), .D_OUT(D_OUT),
    .REQ_READY(REQ_READY), .D_IN(D_IN), .D_VALID(D_VALID),
    .VEC_REQ_VALID(vec_req_valid), .VEC_RW_REQ(VEC_RW_REQ), .VEC_DADDR(vec_daddr),
    .VEC_DOUT(VEC_DOUT), .VEC_REQ_READY(VEC_REQ_READY), .VEC_DIN(VEC_DIN),
    .VEC_DVALID(VEC_DVALID), .INIT_DONE(INIT_DONE)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model and scoreboard
  logic [VW-1:0] model_mem [DEPTH];
  int            model_ptr = 0;
  logic [DW-1:0] exp_s_q[$];
  int            exp_s_cyc[$];
  logic [VW-1:0] exp_v0_q[$];
  int            exp_v0_cyc[$];
  logic [VW-1:0] exp_v1_q[$];
  int            exp_v1_cyc[$];
  logic [DW-1:0] last_s  = '0;
  logic [VW-1:0] last_v0 = '0;
  logic [VW-1:0] last_v1 = '0;

  function automatic int line_of(input logic [AW-1:0] a);
    return int'((a / 64) % DEPTH);
  endfunction

  function automatic int word_of(input logic [AW-1:0] a);
    return int'((a / 8) % 8);
  endfunction

  always @(negedge CLK) begin : monitor
    logic [2:0] req_v, rdy_v, exp_g;
    logic [DW-1:0] ed;
    logic [VW-1:0] ev;
    int ec, g, l, w;
    if (!RESET) begin
      exp_s_q.delete(); exp_s_cyc.delete();
      exp_v0_q.delete(); exp_v0_cyc.delete();
      exp_v1_q.delete(); exp_v1_cyc.delete();
      model_ptr = 0;
      last_s = '0; last_v0 = '0; last_v1 = '0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end else begin
      n_checks++;
      if (D_VALID) begin
        if (exp_s_q.size() == 0) begin
          n_fail++; $display("FAIL scalar_unexpected cyc=%0d got=%h", cyc, D_IN);
        end else begin
          ed = exp_s_q.pop_front(); ec = exp_s_cyc.pop_front();
          if (D_IN !== ed || cyc != ec) begin
            n_fail++; $display("FAIL scalar_resp got=%h@%0d exp=%h@%0d", D_IN, cyc, ed, ec);
          end
        end
        last_s = D_IN;
      end else if (exp_s_cyc.size() != 0 && exp_s_cyc[0] <= cyc) begin
        n_fail++; $display("FAIL scalar_missing cyc=%0d exp_cyc=%0d", cyc, exp_s_cyc[0]);
        void'(exp_s_q.pop_front()); void'(exp_s_cyc.pop_front());
      end else if (D_IN !== last_s) begin
        n_fail++; $display("FAIL scalar_hold got=%h exp=%h", D_IN, last_s);
      end

      n_checks++;
      if (VEC_DVALID[0]) begin
        if (exp_v0_q.size() == 0) begin
          n_fail++; $display("FAIL vec0_unexpected cyc=%0d", cyc);
        end else begin
          ev = exp_v0_q.pop_front(); ec = exp_v0_cyc.pop_front();
          if (VEC_DIN[0] !== ev || cyc != ec) begin
            n_fail++; $display("FAIL vec0_resp got=%h@%0d exp=%h@%0d", VEC_DIN[0], cyc, ev, ec);
          end
        end
        last_v0 = VEC_DIN[0];
      end else if (exp_v0_cyc.size() != 0 && exp_v0_cyc[0] <= cyc) begin
        n_fail++; $display("FAIL vec0_missing cyc=%0d exp_cyc=%0d", cyc, exp_v0_cyc[0]);
        void'(exp_v0_q.pop_front()); void'(exp_v0_cyc.pop_front());
      end else if (VEC_DIN[0] !== last_v0) begin
        n_fail++; $display("FAIL vec0_hold cyc=%0d", cyc);
      end

      n_checks++;
      if (VEC_DVALID[1]) begin
        if (exp_v1_q.size() == 0) begin
          n_fail++; $display("FAIL vec1_unexpected cyc=%0d", cyc);
        end else begin
          ev = exp_v1_q.pop_front(); ec = exp_v1_cyc.pop_front();
          if (VEC_DIN[1] !== ev || cyc != ec) begin
            n_fail++; $display("FAIL vec1_resp got=%h@%0d exp=%h@%0d", VEC_DIN[1], cyc, ev, ec);
          end
        end
        last_v1 = VEC_DIN[1];
      end else if (exp_v1_cyc.size() != 0 && exp_v1_cyc[0] <= cyc) begin
        n_fail++; $display("FAIL vec1_missing cyc=%0d exp_cyc=%0d", cyc, exp_v1_cyc[0]);
        void'(exp_v1_q.pop_front()); void'(exp_v1_cyc.pop_front());
      end else if (VEC_DIN[1] !== last_v1) begin
        n_fail++; $display("FAIL vec1_hold cyc=%0d", cyc);
      end

      // round robin: first valid requester at or after the pointer wins
      req_v = {vv1, vv0, REQ_VALID};
      rdy_v = {VEC_REQ_READY[1], VEC_REQ_READY[0], REQ_READY};
      exp_g = 3'b000;
      g = -1;
      if (INIT_DONE) begin
        for (int k = 0; k < 3; k++) begin
          if (g < 0 && req_v[(model_ptr + k) % 3]) g = (model_ptr + k) % 3;
        end
      end
      if (g >= 0) exp_g[g] = 1'b1;
      n_checks++;
      if (rdy_v !== exp_g) begin
        n_fail++; $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, rdy_v, exp_g);
      end

      if (REQ_VALID && REQ_READY) begin
        l = line_of(D_ADDR); w = word_of(D_ADDR);
        if (RW_REQ) begin
          model_mem[l][w*DW +: DW] = D_OUT;
          exp_s_q.push_back('0);
        end else begin
          exp_s_q.push_back(model_mem[l][w*DW +: DW]);
        end
        exp_s_cyc.push_back(cyc + 2);
        model_ptr = 1;
      end
      if (vv0 && VEC_REQ_READY[0]) begin
        l = line_of(va0);
        if (VEC_RW_REQ) begin
          model_mem[l] = VEC_DOUT;
          exp_v0_q.push_back('0);
        end else begin
          exp_v0_q.push_back(model_mem[l]);
        end
        exp_v0_cyc.push_back(cyc + 2);
        model_ptr = 2;
      end
      if (vv1 && VEC_REQ_READY[1]) begin
        exp_v1_q.push_back(model_mem[line_of(va1)]);
        exp_v1_cyc.push_back(cyc + 2);
        model_ptr = 0;
      end
    end
  end

  // driver tasks: called just after a rising edge, return just after the accepting edge
  task automatic scalar_op(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int acc);
    RW_REQ = rw; D_ADDR = a; D_OUT = d; REQ_VALID = 1'b1; acc = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (REQ_READY) begin acc = cyc; break; end
    end
    if (acc < 0) begin
      n_checks++; n_fail++; $display("FAIL scalar_accept_timeout addr=%h", a);
    end
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
  endtask

  task automatic vec0_op(input logic rw, input logic [AW-1:0] a, input logic [VW-1:0] d,
                         output int acc);
    VEC_RW_REQ = rw; va0 = a; VEC_DOUT = d; vv0 = 1'b1; acc = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (VEC_REQ_READY[0]) begin acc = cyc; break; end
    end
    if (acc < 0) begin
      n_checks++; n_fail++; $display("FAIL vec0_accept_timeout addr=%h", a);
    end
    @(posedge CLK); #1;
    vv0 = 1'b0;
  endtask

  task automatic vec1_op(input logic [AW-1:0] a, output int acc);
    va1 = a; vv1 = 1'b1; acc = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (VEC_REQ_READY[1]) begin acc = cyc; break; end
    end
    if (acc < 0) begin
      n_checks++; n_fail++; $display("FAIL vec1_accept_timeout addr=%h", a);
    end
    @(posedge CLK); #1;
    vv1 = 1'b0;
  endtask

  task automatic wait_resp(input int port, output logic [VW-1:0] data, output int at);
    at = -1; data = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (port == 0 && D_VALID) begin data = VW'(D_IN); at = cyc; break; end
      if (port == 1 && VEC_DVALID[0]) begin data = VEC_DIN[0]; at = cyc; break; end
      if (port == 2 && VEC_DVALID[1]) begin data = VEC_DIN[1]; at = cyc; break; end
    end
    @(posedge CLK); #1;
  endtask

  function automatic logic [VW-1:0] rand_line();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = {$urandom(), $urandom()};
    a[13:6] = 8'($urandom_range(0, 7));
    return a;
  endfunction

  task automatic check_init(input string name);
    int n;
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge CLK); #1;
      if (INIT_DONE) begin n = i; break; end
      n_checks++;
      if (REQ_READY !== 1'b0 || VEC_REQ_READY[0] !== 1'b0 || VEC_REQ_READY[1] !== 1'b0 ||
          D_VALID !== 1'b0) begin
        n_fail++; $display("FAIL %s_ready_in_init cycle=%0d", name, i);
      end
    end
    n_checks++;
    if (n != DEPTH) begin
      n_fail++; $display("FAIL %s_init_cycles got=%0d exp=%0d", name, n, DEPTH);
    end
  endtask

  task automatic test_reset();
    REQ_VALID = 1'b1; RW_REQ = 1'b0; D_ADDR = 64'h40;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if (D_VALID !== 1'b0 || D_IN !== '0) begin
      n_fail++; $display("FAIL reset_scalar_out valid=%b data=%h exp 0/0", D_VALID, D_IN);
    end
    n_checks++;
    if (VEC_DVALID[0] !== 1'b0 || VEC_DVALID[1] !== 1'b0 || VEC_DIN[0] !== '0 || VEC_DIN[1] !== '0) begin
      n_fail++; $display("FAIL reset_vec_out valid=%b%b exp 00 with zero data", VEC_DVALID[0], VEC_DVALID[1]);
    end
    n_checks++;
    if (REQ_READY !== 1'b0 || INIT_DONE !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_done ready=%b done=%b exp 0/0", REQ_READY, INIT_DONE);
    end
    RESET = 1'b1;
    check_init("init1");
    n_checks++;
    if (REQ_READY !== 1'b1) begin
      n_fail++; $display("FAIL first_grant ready=%b exp=1", REQ_READY);
    end
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    n_checks++;
    if (D_VALID !== 1'b0) begin
      n_fail++; $display("FAIL read_latency_early valid=%b exp=0", D_VALID);
    end
    @(posedge CLK); #1;
    n_checks++;
    if (D_VALID !== 1'b1 || D_IN !== 64'h0) begin
      n_fail++; $display("FAIL read_0x40 valid=%b data=%h exp 1/0", D_VALID, D_IN);
    end
  endtask

  task automatic test_rw_basic();
    int acc, at;
    logic [VW-1:0] d, e;
    scalar_op(1'b1, 64'h1008, 64'hDEADBEEFCAFEF00D, acc);
    wait_resp(0, d, at);
    n_checks++;
    if (at != acc + 2 || d !== '0) begin
      n_fail++; $display("FAIL write_ack at=%0d exp=%0d data=%h", at, acc + 2, d);
    end
    vec0_op(1'b0, 64'h1000, '0, acc);
    wait_resp(1, d, at);
    e = '0;
    e[127:64] = 64'hDEADBEEFCAFEF00D;
    n_checks++;
    if (at != acc + 2 || d !== e) begin
      n_fail++; $display("FAIL vec0_read_line at=%0d exp=%0d got=%h exp=%h", at, acc + 2, d, e);
    end
    scalar_op(1'b0, 64'h100C, '0, acc);
    wait_resp(0, d, at);
    n_checks++;
    if (at != acc + 2 || d[DW-1:0] !== 64'hDEADBEEFCAFEF00D) begin
      n_fail++; $display("FAIL scalar_read_word at=%0d exp=%0d got=%h exp=deadbeefcafef00d", at, acc + 2, d[DW-1:0]);
    end
  endtask

  task automatic test_round_robin();
    int acc;
    logic [2:0] got, expv;
    vec1_op(64'h40, acc);
    REQ_VALID = 1'b1; RW_REQ = 1'b0; D_ADDR = 64'h1008;
    vv0 = 1'b1; VEC_RW_REQ = 1'b0; va0 = 64'h1000;
    vv1 = 1'b1; va1 = 64'h2000;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      got  = {VEC_REQ_READY[1], VEC_REQ_READY[0], REQ_READY};
      expv = 3'b001 << (k % 3);
      n_checks++;
      if (got !== expv) begin
        n_fail++; $display("FAIL rr_order step=%0d got=%b exp=%b", k, got, expv);
      end
      @(posedge CLK); #1;
    end
    REQ_VALID = 1'b0; vv0 = 1'b0; vv1 = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic test_vec_forward();
    int a0, a1, at;
    logic [VW-1:0] d, ones;
    ones = '1;
    vec0_op(1'b1, 64'h0, ones, a0);
    vec1_op(64'h0, a1);
    n_checks++;
    if (a1 != a0 + 1) begin
      n_fail++; $display("FAIL fwd_accept_cycle got=%0d exp=%0d", a1, a0 + 1);
    end
    wait_resp(2, d, at);
    n_checks++;
    if (at != a0 + 3 || d !== ones) begin
      n_fail++; $display("FAIL fwd_vec1_read at=%0d exp=%0d got=%h", at, a0 + 3, d);
    end
  endtask

  task automatic test_back_to_back_wrap();
    int aw, ar, at;
    logic [VW-1:0] d;
    scalar_op(1'b1, 64'h4000, 64'h5, aw);
    scalar_op(1'b0, 64'h0, '0, ar);
    wait_resp(0, d, at);
    wait_resp(0, d, at);
    n_checks++;
    if (ar != aw + 1 || at != ar + 2 || d[DW-1:0] !== 64'h5) begin
      n_fail++; $display("FAIL wrap_read acc=%0d/%0d at=%0d got=%h exp=5", aw, ar, at, d[DW-1:0]);
    end
  endtask

  task automatic test_random();
    fork
      begin
        int acc, gap;
        for (int i = 0; i < 40; i++) begin
          gap = $urandom_range(0, 2);
          repeat (gap) begin @(posedge CLK); #1; end
          scalar_op(1'($urandom_range(0, 1)), rand_addr(), {$urandom(), $urandom()}, acc);
        end
      end
      begin
        int acc, gap;
        for (int i = 0; i < 40; i++) begin
          gap = $urandom_range(0, 2);
          repeat (gap) begin @(posedge CLK); #1; end
          vec0_op(1'($urandom_range(0, 1)), rand_addr(), rand_line(), acc);
        end
      end
      begin
        int acc, gap;
        for (int i = 0; i < 40; i++) begin
          gap = $urandom_range(0, 2);
          repeat (gap) begin @(posedge CLK); #1; end
          vec1_op(rand_addr(), acc);
        end
      end
    join
    repeat (6) @(posedge CLK);
    #1;
    n_checks++;
    if (exp_s_q.size() + exp_v0_q.size() + exp_v1_q.size() != 0) begin
      n_fail++; $display("FAIL random_drain pending=%0d exp=0", exp_s_q.size() + exp_v0_q.size() + exp_v1_q.size());
    end
  endtask

  task automatic test_reset_inflight();
    int acc, at;
    logic [VW-1:0] d;
    scalar_op(1'b0, 64'h1008, '0, acc);
    #2 RESET = 1'b0;
    #1;
    n_checks++;
    if (D_VALID !== 1'b0 || INIT_DONE !== 1'b0 || REQ_READY !== 1'b0) begin
      n_fail++; $display("FAIL async_reset valid=%b done=%b ready=%b exp 000", D_VALID, INIT_DONE, REQ_READY);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      n_checks++;
      if (D_VALID !== 1'b0) begin
        n_fail++; $display("FAIL dropped_resp cycle=%0d valid=%b exp=0", k, D_VALID);
      end
    end
    @(posedge CLK); #1;
    RESET = 1'b1;
    check_init("init2");
    scalar_op(1'b0, 64'h1008, '0, acc);
    wait_resp(0, d, at);
    n_checks++;
    if (at != acc + 2 || d[DW-1:0] !== 64'h0) begin
      n_fail++; $display("FAIL cleared_after_reinit at=%0d exp=%0d got=%h exp=0", at, acc + 2, d[DW-1:0]);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rw_basic();
    test_round_robin();
    test_vec_forward();
    test_back_to_back_wrap();
    test_random();
    test_reset_inflight();
    repeat (4) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
